// File: rtl/jtcop_snd_pkg.sv
// Shared types and default midres/cop sound-map decode constants for the sound bus controller.
package jtcop_snd_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wait_st_t;

  localparam int SND_AW   = 21;
  localparam int SND_NDEV = 6;

  localparam int SND_RAM   = 0;
  localparam int SND_OPL   = 1;
  localparam int SND_OPN   = 2;
  localparam int SND_OKI   = 3;
  localparam int SND_ROM   = 4;
  localparam int SND_LATCH = 5;

  // Device 0 sits in the lowest slice; ROM covers the whole lower megabyte.
  localparam logic [SND_NDEV*SND_AW-1:0] SND_MASK = {
    21'h1fffff, 21'h100000, 21'h1fffff, 21'h1ffffe, 21'h1ffffe, 21'h1fe000
  };
  localparam logic [SND_NDEV*SND_AW-1:0] SND_MATCH = {
    21'h140000, 21'h000000, 21'h130000, 21'h110000, 21'h100000, 21'h1f0000
  };

endpackage

// File: rtl/jtcop_snd_cmdfifo.sv
// Main-to-sound command FIFO: 8-bit entries, occupancy count, registered
// full/irqn flags and a sticky overflow flag for dropped commands.
module jtcop_snd_cmdfifo #(
  parameter int AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       irqn,
  output logic       overflow
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          do_push, do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign dout    = (count == '0) ? 8'hff : mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (!do_push && do_pop)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      irqn     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      irqn  <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/jtcop_snd_busctl.sv
// Sound-CPU bus controller: window decode to one-hot selects, registered read mux,
// WAIT_N generation with timeout for slow devices, and the command FIFO.
//   state   | meaning
//   ST_IDLE | no wait pending, waitn high
//   ST_WAIT | slow device selected without data, waitn low, counting
module jtcop_snd_busctl
  import jtcop_snd_pkg::*;
#(
  parameter int                 AW        = 21,
  parameter int                 NDEV      = 6,
  parameter logic [NDEV*AW-1:0] DEV_MASK  = '0,
  parameter logic [NDEV*AW-1:0] DEV_MATCH = '0,
  parameter logic [NDEV-1:0]    DEV_SLOW  = '0,
  parameter int                 LATCH_DEV = NDEV-1,
  parameter int                 LATCH_AW  = 2,
  parameter int                 WAIT_TO   = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sx,
  input  logic            ce,
  input  logic [AW-1:0]   addr,
  input  logic            wrn,
  input  logic            rdn,
  output logic [7:0]      cpu_din,
  output logic            waitn,
  output logic [NDEV-1:0] dev_cs,
  input  logic [NDEV*8-1:0] dev_dout,
  input  logic [NDEV-1:0] dev_ok,
  input  logic            snreq,
  input  logic [7:0]      latch,
  output logic            latch_full,
  output logic            irqn,
  output logic            timeout,
  output logic            overflow
);

  localparam logic [7:0] TO_LAST = 8'(WAIT_TO - 1);

  logic [NDEV-1:0] hit_1h;
  logic [7:0]      rd_mux, fifo_head;
  logic            fifo_pop, slow_sel, slow_ok, ignore;
  logic [7:0]      wait_cnt;
  wait_st_t        st;

  // Scan from the top so the lowest-index hit is the one left standing.
  always_comb begin
    hit_1h = '0;
    for (int i = NDEV-1; i >= 0; i--) begin
      if ((addr & DEV_MASK[i*AW +: AW]) == DEV_MATCH[i*AW +: AW]) begin
        hit_1h    = '0;
        hit_1h[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = 8'hff;
    for (int i = 0; i < NDEV; i++) begin
      if (dev_cs[i])
        rd_mux = (i == LATCH_DEV) ? fifo_head : dev_dout[i*8 +: 8];
    end
  end

  assign slow_sel = |(dev_cs & DEV_SLOW);
  assign slow_ok  = |(dev_cs & DEV_SLOW & dev_ok);
  assign fifo_pop = ce && dev_cs[LATCH_DEV] && !rdn && wrn;

  always_ff @(posedge clk) begin
    if (rst) begin
      dev_cs  <= '0;
      cpu_din <= 8'hff;
    end else begin
      if (sx)
        dev_cs <= hit_1h;
      else if (ce)
        dev_cs <= '0;
      cpu_din <= rd_mux;
    end
  end

  // After a forced release the device stays ignored until its select drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      waitn    <= 1'b1;
      wait_cnt <= '0;
      timeout  <= 1'b0;
      ignore   <= 1'b0;
    end else begin
      if (dev_cs == '0) ignore <= 1'b0;
      case (st)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (slow_sel && !slow_ok && !ignore) begin
            st    <= ST_WAIT;
            waitn <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!slow_sel || slow_ok) begin
            st       <= ST_IDLE;
            waitn    <= 1'b1;
            wait_cnt <= '0;
          end else if (wait_cnt == TO_LAST) begin
            st       <= ST_IDLE;
            waitn    <= 1'b1;
            timeout  <= 1'b1;
            ignore   <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  jtcop_snd_cmdfifo #(.AW(LATCH_AW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (snreq),
    .din      (latch),
    .pop      (fifo_pop),
    .dout     (fifo_head),
    .full     (latch_full),
    .irqn     (irqn),
    .overflow (overflow)
  );

endmodule
